// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the datapath. Runs a
// fetch (T0-T2) and a class-dependent execute (T3-T7), one step per clock.
// Memory steps wait on a ready handshake and fault on timeout.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   run               start/continue fetching, sampled at instruction ends
//   ir [31:0]         instruction register contents from the datapath
//   mem_ready         memory has completed the current read/write
//   *_enable, read, write, Gra/Grb/Grc, Rout, BAout, *_select
//                     datapath control strobes (Moore decode of the step)
//   alu_instruction   ALU operation code, valid in T4
//   step              current T index 0-7, 15 when not executing
//   busy/halted/fault status; illegal_op one-cycle pulse in T3
module control_sequencer #(
  parameter int OPCODE_W    = 5,
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PC_enable,
  output logic                PC_increment_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                MAR_enable,
  output logic                MDR_enable,
  output logic                r_enable,
  output logic                read,
  output logic                write,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rout,
  output logic                BAout,
  output logic                PC_select,
  output logic                Z_LO_select,
  output logic                MDR_select,
  output logic                c_select,
  output logic [ALU_OP_W-1:0] alu_instruction,
  output logic [3:0]          step,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic                illegal_op
);

  // T-steps share their index with the step output; bit 3 marks non-executing states.
  localparam logic [3:0] S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
                         S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
                         S_IDLE = 4'd8, S_HALT = 4'd9, S_FAULT = 4'd10;

  localparam logic [2:0] C_LD = 3'd0, C_LDI = 3'd1, C_ST = 3'd2, C_RALU = 3'd3,
                         C_IALU = 3'd4, C_NOP = 3'd5, C_HALT = 3'd6;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0]          state, nxt;
  logic [7:0]          wait_cnt;
  logic [2:0]          cls_q, cls, dec_cls;
  logic [ALU_OP_W-1:0] alu_q, alu_code, dec_alu;
  logic                dec_ill, mem_step;
  logic [OPCODE_W-1:0] op;

  assign op = ir[31:32-OPCODE_W];

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[31-OPCODE_W:0];

  always_comb begin
    dec_cls = C_NOP;
    dec_alu = '0;
    dec_ill = 1'b0;
    if (op == OPCODE_W'(0))       dec_cls = C_LD;
    else if (op == OPCODE_W'(1))  dec_cls = C_LDI;
    else if (op == OPCODE_W'(2))  dec_cls = C_ST;
    else if (op >= OPCODE_W'(3) && op <= OPCODE_W'(11)) begin
      dec_cls = C_RALU;
      dec_alu = ALU_OP_W'(op - OPCODE_W'(3));
    end
    else if (op == OPCODE_W'(12)) dec_cls = C_IALU;
    else if (op == OPCODE_W'(13)) begin dec_cls = C_IALU; dec_alu = ALU_OP_W'(2); end
    else if (op == OPCODE_W'(14)) begin dec_cls = C_IALU; dec_alu = ALU_OP_W'(3); end
    else if (op == OPCODE_W'(26)) dec_cls = C_NOP;
    else if (op == OPCODE_W'(27)) dec_cls = C_HALT;
    else                          dec_ill = 1'b1;
  end

  // IR is written on the edge leaving T2, so during T3 the class comes
  // straight from ir; it is captured on the edge leaving T3 for T4-T7.
  assign cls      = (state == S_T3) ? dec_cls : cls_q;
  assign alu_code = (state == S_T3) ? dec_alu : alu_q;

  assign mem_step = (state == S_T1) ||
                    (state == S_T6 && cls == C_LD) ||
                    (state == S_T7 && cls == C_ST);

  always_comb begin
    logic [3:0] fin;
    fin = run ? S_T0 : S_IDLE;
    nxt = state;
    case (state)
      S_IDLE:  nxt = run ? S_T0 : S_IDLE;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = S_T2;
      S_T2:    nxt = S_T3;
      S_T3:    nxt = (cls == C_HALT) ? S_HALT : (cls == C_NOP) ? fin : S_T4;
      S_T4:    nxt = S_T5;
      S_T5:    nxt = (cls == C_LD || cls == C_ST) ? S_T6 : fin;
      S_T6:    nxt = S_T7;
      S_T7:    nxt = fin;
      S_HALT,
      S_FAULT: nxt = state;
      default: nxt = S_IDLE;
    endcase
    // A memory step holds until ready, or faults once its wait budget is spent.
    if (mem_step && !mem_ready)
      nxt = (wait_cnt == WAIT_LAST) ? S_FAULT : state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      cls_q    <= C_NOP;
      alu_q    <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= (mem_step && nxt == state) ? wait_cnt + 8'd1 : 8'd0;
      if (state == S_T3) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
      end
    end
  end

  always_comb begin
    PC_enable = 1'b0; PC_increment_enable = 1'b0; IR_enable = 1'b0;
    Y_enable = 1'b0; Z_enable = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0;
    r_enable = 1'b0; read = 1'b0; write = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; Rout = 1'b0; BAout = 1'b0; PC_select = 1'b0;
    Z_LO_select = 1'b0; MDR_select = 1'b0; c_select = 1'b0;
    alu_instruction = '0;
    case (state)
      S_T0: begin PC_select = 1'b1; MAR_enable = 1'b1; end
      S_T1: begin PC_increment_enable = 1'b1; read = 1'b1; MDR_enable = 1'b1; end
      S_T2: begin MDR_select = 1'b1; IR_enable = 1'b1; end
      S_T3: begin
        if (cls == C_LD || cls == C_LDI || cls == C_ST) begin
          Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
        end else if (cls == C_RALU || cls == C_IALU) begin
          Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
        end
      end
      S_T4: begin
        Z_enable = 1'b1;
        if (cls == C_RALU) begin
          Grc = 1'b1; Rout = 1'b1; alu_instruction = alu_code;
        end else begin
          c_select = 1'b1;
          if (cls == C_IALU) alu_instruction = alu_code;
        end
      end
      S_T5: begin
        Z_LO_select = 1'b1;
        if (cls == C_LD || cls == C_ST) MAR_enable = 1'b1;
        else begin Gra = 1'b1; r_enable = 1'b1; end
      end
      S_T6: begin
        MDR_enable = 1'b1;
        if (cls == C_ST) begin Gra = 1'b1; Rout = 1'b1; end
        else             read = 1'b1;
      end
      S_T7: begin
        if (cls == C_ST) write = 1'b1;
        else begin MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
      end
      default: ;
    endcase
  end

  assign step       = state[3] ? 4'hF : state;
  assign busy       = ~state[3];
  assign halted     = (state == S_HALT);
  assign fault      = (state == S_FAULT);
  assign illegal_op = (state == S_T3) && dec_ill;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes the
// expected output vector; the negedge monitor pops and compares.
module tb_control_sequencer;
  localparam int TO = 15;

  // Control bit positions in the packed observation vector.
  localparam int PCE = 0, PCI = 1, IRE = 2, YE = 3, ZE = 4, MARE = 5, MDRE = 6,
                 RE = 7, RD = 8, WR = 9, GA = 10, GB = 11, GC = 12, RO = 13,
                 BA = 14, PCS = 15, ZLO = 16, MDRS = 17, CS = 18;
  localparam int C_LD = 0, C_LDI = 1, C_ST = 2, C_RA = 3, C_IA = 4,
                 C_NOP = 5, C_HLT = 6, C_ILL = 7;
  localparam logic [31:0] IDLE_V  = 32'hF000_0000;
  localparam logic [31:0] HALT_V  = 32'hF400_0000;
  localparam logic [31:0] FAULT_V = 32'hF200_0000;

  logic clk = 1'b0, reset, run, mem_ready;
  logic [31:0] ir;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
        MAR_enable, MDR_enable, r_enable, read, write, Gra, Grb, Grc, Rout,
        BAout, PC_select, Z_LO_select, MDR_select, c_select;
  logic [4:0] alu_instruction;
  logic [3:0] step;
  logic busy, halted, fault, illegal_op;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_W(5), .ALU_OP_W(5), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout),
    .BAout(BAout), .PC_select(PC_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .c_select(c_select),
    .alu_instruction(alu_instruction), .step(step), .busy(busy),
    .halted(halted), .fault(fault), .illegal_op(illegal_op)
  );

  logic [31:0] obs;
  assign obs = {step, busy, halted, fault, illegal_op, alu_instruction,
                c_select, MDR_select, Z_LO_select, PC_select, BAout, Rout,
                Grc, Grb, Gra, write, read, r_enable, MDR_enable, MAR_enable,
                Z_enable, Y_enable, IR_enable, PC_increment_enable, PC_enable};

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [31:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, obs, e);
    end
  end

  // Expected outputs for class c in step t (spec step table).
  function automatic logic [31:0] ev(int c, int t, logic [4:0] a);
    logic [18:0] k;
    logic [4:0]  al;
    logic        ill;
    bit ldc;
    k = '0; al = '0; ill = 1'b0;
    ldc = (c == C_LD || c == C_LDI || c == C_ST);
    case (t)
      0: begin k[PCS] = 1'b1; k[MARE] = 1'b1; end
      1: begin k[PCI] = 1'b1; k[RD] = 1'b1; k[MDRE] = 1'b1; end
      2: begin k[MDRS] = 1'b1; k[IRE] = 1'b1; end
      3: if (ldc) begin k[GB] = 1'b1; k[BA] = 1'b1; k[YE] = 1'b1; end
         else if (c == C_RA || c == C_IA) begin k[GB] = 1'b1; k[RO] = 1'b1; k[YE] = 1'b1; end
         else if (c == C_ILL) ill = 1'b1;
      4: if (ldc) begin k[CS] = 1'b1; k[ZE] = 1'b1; end
         else if (c == C_RA) begin k[GC] = 1'b1; k[RO] = 1'b1; k[ZE] = 1'b1; al = a; end
         else begin k[CS] = 1'b1; k[ZE] = 1'b1; al = a; end
      5: if (c == C_LD || c == C_ST) begin k[ZLO] = 1'b1; k[MARE] = 1'b1; end
         else begin k[ZLO] = 1'b1; k[GA] = 1'b1; k[RE] = 1'b1; end
      6: if (c == C_LD) begin k[RD] = 1'b1; k[MDRE] = 1'b1; end
         else begin k[GA] = 1'b1; k[RO] = 1'b1; k[MDRE] = 1'b1; end
      7: if (c == C_LD) begin k[MDRS] = 1'b1; k[GA] = 1'b1; k[RE] = 1'b1; end
         else k[WR] = 1'b1;
      default: ;
    endcase
    return {4'(t), 1'b1, 1'b0, 1'b0, ill, al, k};
  endfunction

  // One clock: drive inputs, push this cycle's expectation, advance.
  task automatic cyc(input logic [31:0] e, input string tag,
                     input logic rdy, input logic rn, input logic rs);
    mem_ready = rdy; run = rn; reset = rs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  // Runs one instruction from T0. w1/wm are T1/data-step wait cycles;
  // abort_t asserts reset in that step. outcome: 0 done, 1 fault, 2 aborted, 3 halted.
  task automatic instr(input logic [31:0] irv, input int c, input logic [4:0] a,
                       input int w1, input int wm, input logic rn_end,
                       input int abort_t, output int outcome);
    int lastt, w;
    bit ismem;
    logic rn;
    string tg;
    ir = irv;
    outcome = 0;
    lastt = (c == C_LD || c == C_ST) ? 7 :
            (c == C_LDI || c == C_RA || c == C_IA) ? 5 : 3;
    for (int t = 0; t <= lastt; t++) begin
      tg = $sformatf("op%0d_t%0d", irv[31:27], t);
      rn = (t == lastt) ? rn_end : 1'($urandom_range(0, 1));
      if (t == abort_t) begin
        cyc(ev(c, t, a), tg, 1'b0, 1'b1, 1'b1);
        outcome = 2;
        return;
      end
      ismem = (t == 1) || (c == C_LD && t == 6) || (c == C_ST && t == 7);
      if (ismem) begin
        w = (t == 1) ? w1 : wm;
        for (int i = 0; i < w && i < TO; i++) cyc(ev(c, t, a), tg, 1'b0, rn, 1'b0);
        if (w >= TO) begin outcome = 1; return; end
        cyc(ev(c, t, a), tg, 1'b1, rn, 1'b0);
      end else begin
        cyc(ev(c, t, a), tg, 1'($urandom_range(0, 1)), rn, 1'b0);
      end
    end
    if (c == C_HLT) outcome = 3;
  endtask

  int o;

  initial begin
    reset = 1'b1; run = 1'b1; mem_ready = 1'b0; ir = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    cyc(IDLE_V, "rst0", 1'b0, 1'b1, 1'b1);
    cyc(IDLE_V, "rst1", 1'b1, 1'b1, 1'b1);
    cyc(IDLE_V, "release", 1'b0, 1'b1, 1'b0);

    instr(32'h0080_0065, C_LD, 5'd0, 0, 0, 1'b1, -1, o);
    instr({5'd4, 27'h0123456}, C_RA, 5'd1, 3, 0, 1'b1, -1, o);    // sub, T1 waits 3
    instr({5'd13, 27'h0654321}, C_IA, 5'd2, TO - 1, 0, 1'b1, -1, o); // andi, longest legal wait
    instr({5'd2, 27'h0000100}, C_ST, 5'd0, 0, 3, 1'b1, -1, o);    // store, write waits 3
    instr({5'd1, 27'h0000042}, C_LDI, 5'd0, 0, 0, 1'b1, -1, o);
    instr({5'd3, 27'h0000000}, C_RA, 5'd0, 0, 0, 1'b1, -1, o);
    instr({5'd6, 27'h1000000}, C_RA, 5'd3, 1, 0, 1'b1, -1, o);
    instr({5'd11, 27'h7FFFFFF}, C_RA, 5'd8, 0, 0, 1'b1, -1, o);
    instr({5'd12, 27'h0000007}, C_IA, 5'd0, 0, 0, 1'b1, -1, o);
    instr({5'd14, 27'h0000008}, C_IA, 5'd3, 0, 0, 1'b1, -1, o);
    instr({5'd31, 27'h0000000}, C_ILL, 5'd0, 0, 0, 1'b1, -1, o);
    instr({5'd15, 27'h0000000}, C_ILL, 5'd0, 0, 0, 1'b1, -1, o);
    instr({5'd26, 27'h0000000}, C_NOP, 5'd0, 0, 0, 1'b0, -1, o);
    cyc(IDLE_V, "idle_hold0", 1'b1, 1'b0, 1'b0);
    cyc(IDLE_V, "idle_hold1", 1'b0, 1'b0, 1'b0);
    cyc(IDLE_V, "idle_go", 1'b0, 1'b1, 1'b0);

    instr(32'h0080_0065, C_LD, 5'd0, 1, 2, 1'b0, -1, o);          // run dropped, completes
    cyc(IDLE_V, "ld_end_idle", 1'b0, 1'b1, 1'b0);

    instr(32'h0080_0065, C_LD, 5'd0, 0, 0, 1'b1, 6, o);           // reset during T6
    chk("abort_outcome", 32'(o), 32'd2);
    cyc(IDLE_V, "abort_idle", 1'b0, 1'b0, 1'b0);
    cyc(IDLE_V, "abort_go", 1'b0, 1'b1, 1'b0);

    instr({5'd27, 27'h0000000}, C_HLT, 5'd0, 0, 0, 1'b1, -1, o);
    for (int i = 0; i < 3; i++) cyc(HALT_V, "halt_hold", 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    cyc(HALT_V, "halt_rst", 1'b0, 1'b1, 1'b1);
    cyc(IDLE_V, "post_halt", 1'b0, 1'b1, 1'b0);

    instr(32'h0080_0065, C_LD, 5'd0, TO + 1, 0, 1'b1, -1, o);     // T1 timeout
    chk("fault_outcome", 32'(o), 32'd1);
    for (int i = 0; i < 3; i++) cyc(FAULT_V, "fault_hold", 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    cyc(FAULT_V, "fault_rst", 1'b0, 1'b0, 1'b1);
    cyc(IDLE_V, "post_fault", 1'b0, 1'b0, 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
